uart_word_loader: RTL and testbench

UART_WORD_LOADER -- requirements
Module: uart_word_loader

---
 rtl/uart_word_loader.sv | 165 ++++++++++++++++
 tb/tb_uart_word_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_loader.sv
// uart_word_loader: packs received UART bytes little-endian into 32-bit
// words and writes them to consecutive word addresses from BASE_ADDR.
// Ports: clk, reset (async, active-high); rx_data/rx_status from the UART
//   receiver; enable opens a load session; mem_ack accepts a write;
//   mem_we/mem_addr/mem_wdata write request; busy, word_count, sticky
//   overrun_err and timeout_err status.
// Build option: define UART_LOADER_TIMEOUT_EN to discard a partial word
//   after TIMEOUT_CYCLES idle clocks between bytes.
module uart_word_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_status,
  input  logic        enable,
  input  logic        mem_ack,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic [15:0] word_count,
  output logic        overrun_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE
  } state_t;

  state_t      state_q, state_d;
  logic        rx_status_q;
  logic        enable_q;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        ovr_q, ovr_d;
  logic        strobe;
  logic        en_rise;

  // rx_status stays high until the next start bit, so only its
  // rising edge marks a new byte.
  assign strobe  = rx_status & ~rx_status_q;
  assign en_rise = enable & ~enable_q;

`ifdef UART_LOADER_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_err_q, tmo_err_d;
  logic        tmo_hit;

  assign tmo_hit = (tmo_cnt_q == TIMEOUT_CYCLES - 16'd1);
`else
  // Parameter kept so both builds share one instantiation.
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rx_status_q <= 1'b0;
      enable_q    <= 1'b0;
      idx_q       <= 2'd0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= 32'd0;
      wcnt_q      <= 16'd0;
      ovr_q       <= 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
      tmo_cnt_q   <= 16'd0;
      tmo_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_status_q <= rx_status;
      enable_q    <= enable;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wcnt_q      <= wcnt_d;
      ovr_q       <= ovr_d;
`ifdef UART_LOADER_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_err_q   <= tmo_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wcnt_d  = wcnt_q;
    ovr_d   = ovr_q;
`ifdef UART_LOADER_TIMEOUT_EN
    // Counter clears on every strobe and whenever it is not counting.
    tmo_cnt_d = 16'd0;
    tmo_err_d = tmo_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (en_rise) begin
          state_d = COLLECT;
          addr_d  = BASE_ADDR;
          idx_d   = 2'd0;
          wcnt_d  = 16'd0;
          ovr_d   = 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
          tmo_err_d = 1'b0;
`endif
        end
      end
      COLLECT: begin
        // Enable falling wins over a same-cycle byte.
        if (!enable) begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end else if (strobe) begin
          wdata_d[{idx_q, 3'b000} +: 8] = rx_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = WRITE;
          end
`ifdef UART_LOADER_TIMEOUT_EN
        end else if (idx_q != 2'd0) begin
          if (tmo_hit) begin
            idx_d     = 2'd0;
            tmo_err_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
          end
`endif
        end
      end
      WRITE: begin
        if (strobe) begin
          ovr_d = 1'b1;
        end
        if (mem_ack) begin
          addr_d  = addr_q + 32'd4;
          wcnt_d  = wcnt_q + 16'd1;
          state_d = enable ? COLLECT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_we      = (state_q == WRITE);
  assign busy        = (state_q != IDLE);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign word_count  = wcnt_q;
  assign overrun_err = ovr_q;
`ifdef UART_LOADER_TIMEOUT_EN
  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_word_loader.sv
// tb_uart_word_loader: random-byte stimulus against a queue model of
// little-endian word packing and sequential word addressing.
module tb_uart_word_loader;

  localparam logic [31:0] BASE = 32'hFFFF_FFF8;
  localparam logic [15:0] TMO  = 16'd20;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_status;
  logic        enable;
  logic        mem_ack;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic [15:0] word_count;
  logic        overrun_err;
  logic        timeout_err;

  uart_word_loader #(
    .BASE_ADDR(BASE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_status(rx_status),
    .enable(enable),
    .mem_ack(mem_ack),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .busy(busy),
    .word_count(word_count),
    .overrun_err(overrun_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: accepted bytes pack four at a time into words at
  // BASE + 4*n for the n-th word of a session.
  logic [7:0]  buf_q[$];
  logic [63:0] exp_q[$];
  int sess_words = 0;
  int issued = 0;
  int nwr = 0;
  int ack_dly = 0;
  bit ack_auto = 1'b1;

  function automatic void m_accept(input logic [7:0] b);
    buf_q.push_back(b);
    if (buf_q.size() == 4) begin
      exp_q.push_back({BASE + 32'(4 * sess_words),
                       buf_q[3], buf_q[2], buf_q[1], buf_q[0]});
      sess_words++;
      issued++;
      buf_q.delete();
    end
  endfunction

  // Memory side: acks after ack_dly cycles, checks each write against
  // the model and checks the request holds steady while waiting.
  initial begin
    logic [31:0] a, w;
    logic [63:0] e;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_we && ack_auto) begin
        a = mem_addr;
        w = mem_wdata;
        chk("wr_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", a, e[63:32]);
          chk("wr_data", w, e[31:0]);
        end
        for (int i = 0; i < ack_dly; i++) begin
          @(posedge clk); #1;
          chk("hold_we", 32'(mem_we), 32'd1);
          chk("hold_addr", mem_addr, a);
          chk("hold_data", mem_wdata, w);
        end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        nwr++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold,
                           input int gap, input bit acc);
    rx_data   = b;
    rx_status = 1'b1;
    if (acc) m_accept(b);
    repeat (hold) @(posedge clk);
    #1;
    rx_status = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic wait_wr();
    for (int i = 0; i < 300 && nwr != issued; i++) begin
      @(posedge clk); #1;
    end
    chk("wr_done", 32'(nwr), 32'(issued));
  endtask

  task automatic wait_we();
    for (int i = 0; i < 20 && !mem_we; i++) begin
      @(posedge clk); #1;
    end
    chk("we_seen", 32'(mem_we), 32'd1);
  endtask

  task automatic send4(input logic [31:0] w, input bit do_wait);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], int'($urandom_range(1, 3)),
                int'($urandom_range(1, 3)), 1'b1);
    if (do_wait) wait_wr();
  endtask

  task automatic start_session();
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    buf_q.delete();
    sess_words = 0;
    chk("ses_busy", 32'(busy), 32'd1);
    chk("ses_addr", mem_addr, BASE);
    chk("ses_wc", 32'(word_count), 32'd0);
    chk("ses_ovr", 32'(overrun_err), 32'd0);
    chk("ses_tmo", 32'(timeout_err), 32'd0);
  endtask

  initial begin
    logic [31:0] w0;
    reset     = 1'b1;
    rx_data   = 8'h00;
    rx_status = 1'b0;
    enable    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_ovr", 32'(overrun_err), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);

    // Basic word 11,22,33,44
    start_session();
    ack_dly = 0;
    send4(32'h4433_2211, 1'b1);
    chk("w1_data", mem_wdata, 32'h4433_2211);
    chk("w1_wc", 32'(word_count), 32'd1);
    chk("w1_we", 32'(mem_we), 32'd0);

    // Delayed ack, address wraps past 2^32
    ack_dly = 5;
    send4($urandom, 1'b1);
    send4($urandom, 1'b1);
    chk("dly_wc", 32'(word_count), 32'(sess_words));
    chk("dly_addr", mem_addr, BASE + 32'(4 * sess_words));

    // Long rx_status high gives one byte
    ack_dly = int'($urandom_range(0, 3));
    send_byte(8'hA5, 100, 2, 1'b1);
    for (int i = 0; i < 3; i++)
      send_byte(8'(i + 1), 1, 1, 1'b1);
    wait_wr();
    chk("hold100_wc", 32'(word_count), 32'(sess_words));

    // Overrun during write
    ack_dly = 8;
    send4($urandom, 1'b0);
    wait_we();
    send_byte(8'hEE, 1, 1, 1'b0);
    chk("ovr_set", 32'(overrun_err), 32'd1);
    wait_wr();
    send4($urandom, 1'b1);
    chk("ovr_sticky", 32'(overrun_err), 32'd1);
    chk("ovr_wc", 32'(word_count), 32'(sess_words));

    // Enable drop with a same-cycle byte discards the partial word
    ack_dly = 0;
    send_byte($urandom, 1, 1, 1'b1);
    send_byte($urandom, 1, 1, 1'b1);
    w0        = mem_wdata;
    rx_data   = ~w0[23:16];
    rx_status = 1'b1;
    enable    = 1'b0;
    @(posedge clk); #1;
    rx_status = 1'b0;
    buf_q.delete();
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_wdata", mem_wdata, w0);
    repeat (3) @(posedge clk);
    #1;
    chk("drop_nowr", 32'(nwr), 32'(issued));
    start_session();
    send4($urandom, 1'b1);
    chk("drop_wc", 32'(word_count), 32'd1);

    // Inter-byte idle gap
    start_session();
    send_byte($urandom, 1, 1, 1'b1);
    send_byte($urandom, 1, 1, 1'b1);
    repeat (25) @(posedge clk);
    #1;
    chk("gap_nowr", 32'(nwr), 32'(issued));
    chk("gap_busy", 32'(busy), 32'd1);
`ifdef UART_LOADER_TIMEOUT_EN
    chk("gap_tmo", 32'(timeout_err), 32'd1);
    buf_q.delete();
    send4($urandom, 1'b1);
    chk("gap_tmo_sticky", 32'(timeout_err), 32'd1);
`else
    chk("gap_tmo", 32'(timeout_err), 32'd0);
    send_byte($urandom, 1, 1, 1'b1);
    send_byte($urandom, 1, 1, 1'b1);
    wait_wr();
`endif
    chk("gap_wc", 32'(word_count), 32'd1);

    // Enable drops while a write is pending
    ack_dly = 4;
    send4($urandom, 1'b0);
    wait_we();
    enable = 1'b0;
    wait_wr();
    chk("endw_busy", 32'(busy), 32'd0);
    chk("endw_we", 32'(mem_we), 32'd0);
    chk("endw_wc", 32'(word_count), 32'(sess_words));

    // Randomized run
    start_session();
    for (int n = 0; n < 6; n++) begin
      ack_dly = int'($urandom_range(0, 6));
      send4($urandom, 1'b1);
      chk("rnd_wc", 32'(word_count), 32'(sess_words));
    end

    // Reset while a write is pending
    ack_auto = 1'b0;
    send4($urandom, 1'b0);
    wait_we();
    reset = 1'b1;
    #1;
    chk("rstw_we", 32'(mem_we), 32'd0);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_wc", 32'(word_count), 32'd0);
    chk("rstw_addr", mem_addr, BASE);
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    issued--;
    repeat (2) @(posedge clk);
    #1;
    chk("rstw_nowr", 32'(nwr), 32'(issued));
    chk("rstw_idle", 32'(busy), 32'd0);
    ack_auto = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
